// File: rtl/nrzi_unstuff_deser_if.sv
// Bus between the edge/sync detector (master) and the NRZI decoder/deserialiser (slave).
interface nrzi_unstuff_deser_if #(
    parameter int WORD_W = 8
);
    logic              d_plus;
    logic              shift_enable;
    logic              eop;
    logic              d_orig;
    logic              bit_valid;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              stuff_err;
    logic              frag_err;

    modport master (
        output d_plus, shift_enable, eop,
        input  d_orig, bit_valid, word_out, word_valid, stuff_err, frag_err
    );

    modport slave (
        input  d_plus, shift_enable, eop,
        output d_orig, bit_valid, word_out, word_valid, stuff_err, frag_err
    );
endinterface

// File: rtl/nrzi_unstuff_deser.sv
// USB receive-path decoder: NRZI decode, bit-unstuffing and LSB-first deserialisation,
// with stuff-violation and fragmented-packet flags.
module nrzi_unstuff_deser #(
    parameter int STUFF_LEN  = 6,
    parameter int WORD_W     = 8,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    nrzi_unstuff_deser_if.slave  bus
);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int BW = $clog2(WORD_W);

    typedef enum logic {RUN, ERR} state_t;

    state_t            state, state_nxt;
    logic              prev_level, prev_nxt;
    logic [OW-1:0]     ones_cnt, ones_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [WORD_W-1:0] word_reg, word_nxt;
    logic              d_orig_reg, d_orig_nxt;
    logic              bv_reg, bv_nxt;
    logic              wv_reg, wv_nxt;
    logic              se_reg, se_nxt;
    logic              fe_reg, fe_nxt;

    logic              dec;
    logic [WORD_W-1:0] shifted;

    // A decoded 1 is "no transition" relative to the previous sampled level.
    assign dec     = (bus.d_plus == prev_level);
    assign shifted = {dec, shreg[WORD_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            prev_level <= IDLE_LEVEL;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            word_reg   <= '0;
            d_orig_reg <= 1'b1;
            bv_reg     <= 1'b0;
            wv_reg     <= 1'b0;
            se_reg     <= 1'b0;
            fe_reg     <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_level <= prev_nxt;
            ones_cnt   <= ones_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            word_reg   <= word_nxt;
            d_orig_reg <= d_orig_nxt;
            bv_reg     <= bv_nxt;
            wv_reg     <= wv_nxt;
            se_reg     <= se_nxt;
            fe_reg     <= fe_nxt;
        end
    end

    // EOP outranks everything, so an ERR packet always recovers at its end.
    always_comb begin
        state_nxt  = state;
        prev_nxt   = prev_level;
        ones_nxt   = ones_cnt;
        bit_nxt    = bit_cnt;
        shreg_nxt  = shreg;
        word_nxt   = word_reg;
        d_orig_nxt = d_orig_reg;
        bv_nxt     = 1'b0;
        wv_nxt     = 1'b0;
        se_nxt     = 1'b0;
        fe_nxt     = 1'b0;

        if (bus.shift_enable) begin
            if (bus.eop) begin
                fe_nxt    = (state == RUN) && (bit_cnt != '0);
                prev_nxt  = IDLE_LEVEL;
                ones_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = RUN;
            end else begin
                prev_nxt = bus.d_plus;
                if (state == RUN) begin
                    if (ones_cnt == OW'(STUFF_LEN)) begin
                        ones_nxt = '0;
                        if (dec) begin
                            se_nxt    = 1'b1;
                            bit_nxt   = '0;
                            state_nxt = ERR;
                        end
                    end else begin
                        d_orig_nxt = dec;
                        bv_nxt     = 1'b1;
                        ones_nxt   = dec ? ones_cnt + OW'(1) : '0;
                        shreg_nxt  = shifted;
                        if (bit_cnt == BW'(WORD_W - 1)) begin
                            word_nxt = shifted;
                            wv_nxt   = 1'b1;
                            bit_nxt  = '0;
                        end else begin
                            bit_nxt = bit_cnt + BW'(1);
                        end
                    end
                end
            end
        end
    end

    assign bus.d_orig     = d_orig_reg;
    assign bus.bit_valid  = bv_reg;
    assign bus.word_out   = word_reg;
    assign bus.word_valid = wv_reg;
    assign bus.stuff_err  = se_reg;
    assign bus.frag_err   = fe_reg;
endmodule

// File: tb/tb_nrzi_unstuff_deser.sv
// Directed bench for nrzi_unstuff_deser: default 8-bit/6-stuff instance plus a 4-bit/3-stuff instance.
module tb_nrzi_unstuff_deser;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nrzi_unstuff_deser_if #(.WORD_W(8)) bus_a ();
    nrzi_unstuff_deser_if #(.WORD_W(4)) bus_b ();

    nrzi_unstuff_deser dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    nrzi_unstuff_deser #(.STUFF_LEN(3), .WORD_W(4)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    int checks   = 0;
    int failures = 0;

    int          n_bv, n_wv, n_se, n_fe, n_dorig1, n_wv_nobv;
    logic [31:0] last_word;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearCounts();
        n_bv      = 0;
        n_wv      = 0;
        n_se      = 0;
        n_fe      = 0;
        n_dorig1  = 0;
        n_wv_nobv = 0;
    endtask

    // One strobe on the chosen instance; outputs are sampled 1 ns after the edge.
    task automatic applyStimulus(input bit sel_b, input logic lvl, input logic e);
        logic bv, wv, se, fe, dor;
        @(negedge clk);
        if (sel_b) begin
            bus_b.d_plus = lvl; bus_b.eop = e; bus_b.shift_enable = 1'b1;
        end else begin
            bus_a.d_plus = lvl; bus_a.eop = e; bus_a.shift_enable = 1'b1;
        end
        @(posedge clk);
        #1;
        bv  = sel_b ? bus_b.bit_valid  : bus_a.bit_valid;
        wv  = sel_b ? bus_b.word_valid : bus_a.word_valid;
        se  = sel_b ? bus_b.stuff_err  : bus_a.stuff_err;
        fe  = sel_b ? bus_b.frag_err   : bus_a.frag_err;
        dor = sel_b ? bus_b.d_orig     : bus_a.d_orig;
        last_word = sel_b ? 32'(bus_b.word_out) : 32'(bus_a.word_out);
        if (bv) n_bv++;
        if (wv) n_wv++;
        if (se) n_se++;
        if (fe) n_fe++;
        if (bv && dor) n_dorig1++;
        if (wv && !bv) n_wv_nobv++;
    endtask

    task automatic sendLevels(input bit sel_b, input logic [31:0] lv, input int n);
        for (int i = 0; i < n; i++) applyStimulus(sel_b, lv[i], 1'b0);
    endtask

    task automatic goIdle();
        @(negedge clk);
        bus_a.shift_enable = 1'b0; bus_a.eop = 1'b0;
        bus_b.shift_enable = 1'b0; bus_b.eop = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        bus_a.shift_enable = 1'b0; bus_a.eop = 1'b0;
        bus_b.shift_enable = 1'b0; bus_b.eop = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_a.d_plus = 1'b1; bus_a.shift_enable = 1'b0; bus_a.eop = 1'b0;
        bus_b.d_plus = 1'b1; bus_b.shift_enable = 1'b0; bus_b.eop = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_d_orig",  32'(bus_a.d_orig), 32'h1);
        checkOutput("rst_word",    32'(bus_a.word_out), 32'h0);
        checkOutput("rst_pulses",  {28'h0, bus_a.bit_valid, bus_a.word_valid, bus_a.stuff_err, bus_a.frag_err}, 32'h0);
        checkOutput("rst_b_d_orig", 32'(bus_b.d_orig), 32'h1);
        rst = 1'b0;

        // Alternating levels decode to all zeros.
        clearCounts();
        sendLevels(1'b0, 32'b1010_1010, 8);
        checkOutput("t1_bv",     32'(n_bv), 32'd8);
        checkOutput("t1_wv",     32'(n_wv), 32'd1);
        checkOutput("t1_dorig",  32'(n_dorig1), 32'd0);
        checkOutput("t1_word",   last_word, 32'h00);
        checkOutput("t1_align",  32'(n_wv_nobv), 32'd0);
        goIdle();
        checkOutput("idle_quiet", {28'h0, bus_a.bit_valid, bus_a.word_valid, bus_a.stuff_err, bus_a.frag_err}, 32'h0);

        // Six ones, a stuff zero, then two more ones.
        pulseReset();
        clearCounts();
        sendLevels(1'b0, 32'b0_0011_1111, 9);
        checkOutput("t2_bv",   32'(n_bv), 32'd8);
        checkOutput("t2_wv",   32'(n_wv), 32'd1);
        checkOutput("t2_word", last_word, 32'hFF);
        checkOutput("t2_serr", 32'(n_se), 32'd0);

        // Seven ones: the stuff slot holds a 1.
        pulseReset();
        clearCounts();
        sendLevels(1'b0, 32'b111_1111, 7);
        checkOutput("t3_bv",   32'(n_bv), 32'd6);
        checkOutput("t3_serr", 32'(n_se), 32'd1);
        checkOutput("t3_wv",   32'(n_wv), 32'd0);
        clearCounts();
        sendLevels(1'b0, 32'b010, 3);
        checkOutput("t3_ignored", 32'(n_bv + n_se), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_err_eop_frag", 32'(n_fe), 32'd0);
        // Levels 1,0,0,1,0,0,1,1 decode LSB-first to 0xA5.
        clearCounts();
        sendLevels(1'b0, 32'b1100_1001, 8);
        checkOutput("t3_recover_bv",   32'(n_bv), 32'd8);
        checkOutput("t3_recover_word", last_word, 32'hA5);

        // Three data bits then EOP.
        clearCounts();
        sendLevels(1'b0, 32'b111, 3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_bv",   32'(n_bv), 32'd3);
        checkOutput("t4_frag", 32'(n_fe), 32'd1);
        checkOutput("t4_wv",   32'(n_wv), 32'd0);
        checkOutput("t4_word_hold", last_word, 32'hA5);

        // Decoded 0,1,1,1,1 leaves bit_cnt=5, ones_cnt=4; reset lands between edges.
        sendLevels(1'b0, 32'b00000, 5);
        checkOutput("t5_pre_bv", 32'(bus_a.bit_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_async_bv",    32'(bus_a.bit_valid), 32'h0);
        checkOutput("t5_async_word",  32'(bus_a.word_out), 32'h0);
        checkOutput("t5_async_dorig", 32'(bus_a.d_orig), 32'h1);
        bus_a.shift_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Levels 0,1,1,1,1,1,0,1 decode LSB-first to 0x3C.
        clearCounts();
        sendLevels(1'b0, 32'b1011_1110, 8);
        checkOutput("t5_bv",   32'(n_bv), 32'd8);
        checkOutput("t5_wv",   32'(n_wv), 32'd1);
        checkOutput("t5_word", last_word, 32'h3C);

        // Word 0xFC ends on the sixth one; next strobe is the stuff slot, then eight zeros.
        pulseReset();
        clearCounts();
        sendLevels(1'b0, 32'b1111_1110, 8);
        checkOutput("t7_word1", last_word, 32'hFC);
        sendLevels(1'b0, 32'b0_1010_1010, 9);
        checkOutput("t7_bv",   32'(n_bv), 32'd16);
        checkOutput("t7_wv",   32'(n_wv), 32'd2);
        checkOutput("t7_word2", last_word, 32'h00);
        checkOutput("t7_serr", 32'(n_se), 32'd0);

        // Narrow instance: levels 1,1,1,0,0 decode to 1,1,1,(stuff 0),1.
        pulseReset();
        clearCounts();
        sendLevels(1'b1, 32'b00111, 5);
        checkOutput("t6_bv",   32'(n_bv), 32'd4);
        checkOutput("t6_wv",   32'(n_wv), 32'd1);
        checkOutput("t6_word", last_word, 32'hF);
        checkOutput("t6_serr", 32'(n_se), 32'd0);
        goIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
